// File: rtl/ser2par_deser.sv
// Serial-to-parallel deserializer: assembles WIDTH-bit words from a bit stream
// and holds each completed word in a one-deep valid/ready output slot.
module ser2par_deser #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1,
    localparam int CW       = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sync_i,
    input  logic             bit_valid_i,
    input  logic             bit_i,
    output logic [WIDTH-1:0] word_o,
    output logic             word_valid_o,
    input  logic             word_ready_i,
    output logic [CW-1:0]    bit_cnt_o,
    output logic             overrun_o
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sh_q, sh_d;
    logic [WIDTH-1:0] word_q, word_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovr_q, ovr_d;

    logic [WIDTH-1:0] sh_base;
    logic [WIDTH-1:0] shifted;
    logic             complete;

    // A sync cycle restarts the frame, so the sampled bit shifts into an empty register.
    always_comb begin
        sh_base = sync_i ? '0 : sh_q;
        if (MSB_FIRST) begin
            shifted = {sh_base[WIDTH-2:0], bit_i};
        end else begin
            shifted = {bit_i, sh_base[WIDTH-1:1]};
        end
        complete = bit_valid_i && !sync_i && (cnt_q == CW'(WIDTH - 1));
    end

    // Bit collection and frame restart.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        sh_d  = sh_q;
        cnt_d = cnt_q;
        ovr_d = ovr_q;
        if (sync_i) begin
            ovr_d = 1'b0;
            if (bit_valid_i) begin
                sh_d  = shifted;
                cnt_d = CW'(1);
            end else begin
                sh_d  = '0;
                cnt_d = '0;
            end
        end else if (bit_valid_i) begin
            if (complete) begin
                sh_d  = '0;
                cnt_d = '0;
            end else begin
                sh_d  = shifted;
                cnt_d = cnt_q + 1'b1;
            end
        end

        // A completion against a full, unaccepted slot is dropped and flagged.
        if (state_q == FULL && complete && !word_ready_i) begin
            ovr_d = 1'b1;
        end
    end

    // Output holding slot.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        unique case (state_q)
            EMPTY: begin
                if (complete) begin
                    word_d  = shifted;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (word_ready_i) begin
                    if (complete) begin
                        word_d = shifted;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            sh_q    <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
        end
    end

    assign word_o       = word_q;
    assign word_valid_o = (state_q == FULL);
    assign bit_cnt_o    = cnt_q;
    assign overrun_o    = ovr_q;

endmodule

// File: tb/tb_ser2par_deser.sv
// Scoreboard bench: two instances (MSB-first and LSB-first) share one stimulus;
// expected words are queued at stimulus time and popped when a word is presented.
module tb_ser2par_deser;

    localparam int W  = 4;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst;
    logic sync_i, bit_valid_i, bit_i, word_ready_i;

    logic [W-1:0]  word_m, word_l;
    logic          valid_m, valid_l;
    logic [CW-1:0] cnt_m, cnt_l;
    logic          ovr_m, ovr_l;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_m[$];
    logic [W-1:0] exp_l[$];
    logic [W-1:0] last_m = '0;
    logic [W-1:0] last_l = '0;
    logic         hold_m = 1'b0;
    logic         hold_l = 1'b0;

    always #5 clk = ~clk;

    ser2par_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .sync_i(sync_i), .bit_valid_i(bit_valid_i), .bit_i(bit_i),
        .word_o(word_m), .word_valid_o(valid_m), .word_ready_i(word_ready_i),
        .bit_cnt_o(cnt_m), .overrun_o(ovr_m)
    );

    ser2par_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .sync_i(sync_i), .bit_valid_i(bit_valid_i), .bit_i(bit_i),
        .word_o(word_l), .word_valid_o(valid_l), .word_ready_i(word_ready_i),
        .bit_cnt_o(cnt_l), .overrun_o(ovr_l)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic bv, input logic b, input logic rdy);
        sync_i       = s;
        bit_valid_i  = bv;
        bit_i        = b;
        word_ready_i = rdy;
        @(posedge clk);
        #1;
        sync_i      = 1'b0;
        bit_valid_i = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] m, input logic [W-1:0] l);
        exp_m.push_back(m);
        exp_l.push_back(l);
    endtask

    // Monitor: a new word is presented when valid is high and the slot was not
    // merely holding an unaccepted word from the previous cycle.
    always @(negedge clk) begin
        if (rst) begin
            hold_m = 1'b0;
            hold_l = 1'b0;
        end else begin
            if (valid_m && !hold_m) begin
                if (exp_m.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL msb_unexpected_word: got %0h expected none", word_m);
                end else begin
                    last_m = exp_m.pop_front();
                    check("msb_word", word_m, last_m);
                end
            end else if (valid_m) begin
                check("msb_word_hold", word_m, last_m);
            end
            if (valid_l && !hold_l) begin
                if (exp_l.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL lsb_unexpected_word: got %0h expected none", word_l);
                end else begin
                    last_l = exp_l.pop_front();
                    check("lsb_word", word_l, last_l);
                end
            end else if (valid_l) begin
                check("lsb_word_hold", word_l, last_l);
            end
            hold_m = valid_m && !word_ready_i;
            hold_l = valid_l && !word_ready_i;
        end
    end

    logic [3:0] seq_bits;
    logic [3:0] exp_cnt_seq [4];
    logic [3:0] s4_words [4];
    logic [3:0] s4_lsb   [4];

    initial begin
        rst = 1'b1;
        sync_i = 1'b0; bit_valid_i = 1'b0; bit_i = 1'b0; word_ready_i = 1'b0;
        #1;
        check("reset_word", {word_m, word_l}, 8'h00);
        check("reset_valid", {valid_m, valid_l}, 2'b00);
        check("reset_cnt", {cnt_m, cnt_l}, 4'h0);
        check("reset_ovr", {ovr_m, ovr_l}, 2'b00);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Basic collection, ready low: 1,0,1,1.
        seq_bits = 4'b1011;
        exp_cnt_seq = '{4'd1, 4'd2, 4'd3, 4'd0};
        push(4'b1011, 4'b1101);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, seq_bits[3-i], 1'b0);
            check("basic_cnt", {2'b00, cnt_m}, exp_cnt_seq[i]);
            check("basic_cnt_lsb", {2'b00, cnt_l}, exp_cnt_seq[i]);
        end
        check("basic_valid", {valid_m, valid_l}, 2'b11);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("accept_valid_falls", {valid_m, valid_l}, 2'b00);

        // Gapped collection: two idle cycles after each bit.
        push(4'b1011, 4'b1101);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, seq_bits[3-i], 1'b0);
            for (int g = 0; g < 2; g++) begin
                step(1'b0, 1'b0, 1'b1, 1'b0);
                check("gap_cnt_hold", {2'b00, cnt_l}, exp_cnt_seq[i]);
            end
        end
        check("gap_valid", {valid_m, valid_l}, 2'b11);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("gap_accept", {valid_m, valid_l}, 2'b00);

        // Backpressure: second word 0110 is dropped.
        push(4'b1011, 4'b1101);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, seq_bits[3-i], 1'b0);
        seq_bits = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) check("ovr_before_drop", {ovr_m, ovr_l}, 2'b00);
            step(1'b0, 1'b1, seq_bits[3-i], 1'b0);
        end
        check("ovr_set", {ovr_m, ovr_l}, 2'b11);
        check("ovr_word_kept", word_m, 4'b1011);
        check("ovr_valid_kept", {valid_m, valid_l}, 2'b11);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("ovr_accept_valid", {valid_m, valid_l}, 2'b00);
        check("ovr_sticky", {ovr_m, ovr_l}, 2'b11);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("ovr_cleared_by_sync", {ovr_m, ovr_l}, 2'b00);
        check("sync_cnt_zero", {cnt_m, cnt_l}, 4'h0);

        // Ready tied high, 16 back-to-back bits.
        s4_words = '{4'b1011, 4'b0110, 4'b1100, 4'b0001};
        s4_lsb   = '{4'b1101, 4'b0110, 4'b0011, 4'b1000};
        for (int w = 0; w < 4; w++) begin
            seq_bits = s4_words[w];
            push(seq_bits, s4_lsb[w]);
            for (int i = 0; i < 4; i++) begin
                step(1'b0, 1'b1, seq_bits[3-i], 1'b1);
                check("stream_valid", {valid_m, valid_l}, (i == 3) ? 2'b11 : 2'b00);
            end
        end
        check("stream_no_ovr", {ovr_m, ovr_l}, 2'b00);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("stream_drained", {valid_m, valid_l}, 2'b00);

        // Sync mid-word: 1,1, sync with bit 0, then 1,0,1.
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("presync_cnt", {2'b00, cnt_m}, 4'd2);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("sync_with_bit_cnt", {cnt_m, cnt_l}, {2'd1, 2'd1});
        push(4'b0101, 4'b1010);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("sync_word_valid", {valid_m, valid_l}, 2'b11);
        check("sync_word_cnt", {cnt_m, cnt_l}, 4'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset while holding a word and mid-frame.
        seq_bits = 4'b1011;
        push(4'b1011, 4'b1101);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, seq_bits[3-i], 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        check("prereset_state", {valid_m, cnt_m}, {1'b1, 2'd2});
        #2 rst = 1'b1;
        #1;
        check("async_rst_word", {word_m, word_l}, 8'h00);
        check("async_rst_valid_cnt", {valid_m, valid_l, cnt_m, cnt_l}, 6'h00);
        check("async_rst_ovr", {ovr_m, ovr_l}, 2'b00);
        @(posedge clk);
        #1 rst = 1'b0;
        seq_bits = 4'b0110;
        push(4'b0110, 4'b0110);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, seq_bits[3-i], 1'b1);
        check("post_reset_valid", {valid_m, valid_l}, 2'b11);
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);

        check("msb_queue_empty", exp_m.size(), 0);
        check("lsb_queue_empty", exp_l.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
